// File: rtl/demux_rr_dispatch_if.sv
// ============================================================================
// Module   : demux_rr_dispatch_if
// Purpose  : Source, sink and status bundle for the 1x4 demux dispatcher.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface demux_rr_dispatch_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             mode;
    logic [1:0]       dest;
    logic [3:0]       lane_en;
    logic [1:0]       sel;
    logic [3:0]       out_valid;
    logic [WIDTH-1:0] out_data;
    logic [3:0]       out_ready;
    logic [CNT_W-1:0] xfer_cnt;

    modport master (
        output in_valid, in_data, mode, dest, lane_en, out_ready,
        input  in_ready, sel, out_valid, out_data, xfer_cnt
    );

    modport slave (
        input  in_valid, in_data, mode, dest, lane_en, out_ready,
        output in_ready, sel, out_valid, out_data, xfer_cnt
    );
endinterface

`default_nettype wire

// File: rtl/demux_rr_dispatch.sv
// ============================================================================
// Module   : demux_rr_dispatch
// Purpose  : One-word buffer routing a valid/ready stream to four lanes,
//            round-robin over enabled lanes or to a fixed destination.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module demux_rr_dispatch #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  wire logic            clk,
    input  wire logic            rst,
    demux_rr_dispatch_if.slave   dmx
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

    logic       w_holding;
    logic       w_fire_out;
    logic       w_fire_in;
    logic       w_can_route;
    logic       w_in_ready;
    logic [1:0] w_rr_base;
    logic [1:0] w_idx;
    logic [1:0] w_tgt;

    assign w_holding   = (state_q == ST_HOLD);
    assign w_fire_out  = w_holding & dmx.out_ready[sel_q];
    assign w_can_route = dmx.mode | (|dmx.lane_en);
    assign w_in_ready  = w_can_route & (~w_holding | dmx.out_ready[sel_q]);
    assign w_fire_in   = dmx.in_valid & w_in_ready;

    // While holding, a pass-through word must search from the lane after the
    // one now completing, since rr_ptr_q has not been updated yet.
    assign w_rr_base = w_holding ? (sel_q + 2'd1) : rr_ptr_q;

    // Scan from farthest to nearest so the nearest enabled lane wins.
    always_comb begin
        w_tgt = w_rr_base;
        w_idx = w_rr_base;
        if (dmx.mode) begin
            w_tgt = dmx.dest;
        end else begin
            for (int k = 3; k >= 0; k--) begin
                w_idx = w_rr_base + 2'(k);
                if (dmx.lane_en[w_idx]) begin
                    w_tgt = w_idx;
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        rr_ptr_d   = rr_ptr_q;
        out_data_d = out_data_q;
        xfer_cnt_d = xfer_cnt_q;
        if (w_fire_out) begin
            xfer_cnt_d = xfer_cnt_q + 1'b1;
            rr_ptr_d   = sel_q + 2'd1;
            state_d    = ST_IDLE;
        end
        if (w_fire_in) begin
            out_data_d = dmx.in_data;
            sel_d      = w_tgt;
            state_d    = ST_HOLD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sel_q      <= 2'd0;
            rr_ptr_q   <= 2'd0;
            out_data_q <= '0;
            xfer_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            rr_ptr_q   <= rr_ptr_d;
            out_data_q <= out_data_d;
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    assign dmx.in_ready  = w_in_ready;
    assign dmx.sel       = sel_q;
    assign dmx.out_valid = w_holding ? (4'b0001 << sel_q) : 4'b0000;
    assign dmx.out_data  = out_data_q;
    assign dmx.xfer_cnt  = xfer_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_demux_rr_dispatch.sv
// ============================================================================
// Module   : tb_demux_rr_dispatch
// Purpose  : Self-checking bench: vector table, corner sequences, random run.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_demux_rr_dispatch;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    demux_rr_dispatch_if #(.WIDTH(8), .CNT_W(16)) dmx ();

    demux_rr_dispatch #(.WIDTH(8), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .dmx (dmx.slave)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural picture of the buffer: occupied or not, which lane, what word.
    bit       m_known = 0;
    bit       m_held  = 0;
    int       m_sel   = 0;
    int       m_rr    = 0;
    int       m_cnt   = 0;
    bit [7:0] m_data  = 8'h00;

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       m;
        logic [1:0] ds;
        logic [3:0] en;
        logic [3:0] ordy;
        logic       e_rdy;
        logic [1:0] e_sel;
        logic [3:0] e_ov;
        logic [7:0] e_od;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic iv, input logic [7:0] d, input logic m,
                        input logic [1:0] ds, input logic [3:0] en, input logic [3:0] ordy);
        int base;
        int tgt;
        bit can, erdy, fo, fi;
        @(negedge clk);
        rst           = r;
        dmx.in_valid  = iv;
        dmx.in_data   = d;
        dmx.mode      = m;
        dmx.dest      = ds;
        dmx.lane_en   = en;
        dmx.out_ready = ordy;
        #1;
        can  = m || (en != 4'b0000);
        erdy = can && (!m_held || ordy[m_sel]);
        if (m_known) begin
            chk("in_ready",  {31'd0, dmx.in_ready}, {31'd0, erdy});
            chk("sel",       {30'd0, dmx.sel}, m_sel);
            chk("out_valid", {28'd0, dmx.out_valid}, m_held ? (32'd1 << m_sel) : 32'd0);
            chk("out_data",  {24'd0, dmx.out_data}, {24'd0, m_data});
            chk("xfer_cnt",  {16'd0, dmx.xfer_cnt}, m_cnt);
        end
        base = m_held ? (m_sel + 1) % 4 : m_rr;
        tgt  = ds;
        if (!m) begin
            for (int i = 0; i < 4; i++) begin
                if (en[(base + i) % 4]) begin
                    tgt = (base + i) % 4;
                    break;
                end
            end
        end
        fo = m_held && ordy[m_sel];
        fi = iv && erdy;
        if (r) begin
            m_known = 1;
            m_held  = 0;
            m_sel   = 0;
            m_rr    = 0;
            m_cnt   = 0;
            m_data  = 8'h00;
        end else begin
            if (fo) begin
                m_cnt  = (m_cnt + 1) % 65536;
                m_rr   = (m_sel + 1) % 4;
                m_held = 0;
            end
            if (fi) begin
                m_held = 1;
                m_sel  = tgt;
                m_data = d;
            end
        end
    endtask

    initial begin
        tbl[0]  = '{1'b1, 8'hA0, 1'b0, 2'd0, 4'hF, 4'hF, 1'b1, 2'd0, 4'h0, 8'h00, 16'd0};
        tbl[1]  = '{1'b1, 8'hA1, 1'b0, 2'd0, 4'hF, 4'hF, 1'b1, 2'd0, 4'h1, 8'hA0, 16'd0};
        tbl[2]  = '{1'b1, 8'hA2, 1'b0, 2'd0, 4'hF, 4'hF, 1'b1, 2'd1, 4'h2, 8'hA1, 16'd1};
        tbl[3]  = '{1'b1, 8'hA3, 1'b0, 2'd0, 4'hF, 4'hF, 1'b1, 2'd2, 4'h4, 8'hA2, 16'd2};
        tbl[4]  = '{1'b1, 8'hA4, 1'b0, 2'd0, 4'hF, 4'hF, 1'b1, 2'd3, 4'h8, 8'hA3, 16'd3};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 2'd0, 4'hF, 4'hF, 1'b1, 2'd0, 4'h1, 8'hA4, 16'd4};
        tbl[6]  = '{1'b1, 8'hB0, 1'b0, 2'd0, 4'hA, 4'hF, 1'b1, 2'd0, 4'h0, 8'hA4, 16'd5};
        tbl[7]  = '{1'b1, 8'hB1, 1'b0, 2'd0, 4'hA, 4'hF, 1'b1, 2'd1, 4'h2, 8'hB0, 16'd5};
        tbl[8]  = '{1'b1, 8'hB2, 1'b0, 2'd0, 4'hA, 4'hF, 1'b1, 2'd3, 4'h8, 8'hB1, 16'd6};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 2'd0, 4'hA, 4'hF, 1'b1, 2'd1, 4'h2, 8'hB2, 16'd7};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 2'd0, 4'hA, 4'hF, 1'b1, 2'd1, 4'h0, 8'hB2, 16'd8};

        dmx.in_valid = 1'b0; dmx.in_data = 8'h00; dmx.mode = 1'b0;
        dmx.dest = 2'd0; dmx.lane_en = 4'h0; dmx.out_ready = 4'h0;

        step(1, 0, 8'h00, 0, 0, 4'h0, 4'h0);
        step(1, 0, 8'h00, 0, 0, 4'h0, 4'h0);

        // Round-robin streaming over all lanes, then over lanes 1 and 3
        for (int i = 0; i < 11; i++) begin
            step(0, tbl[i].iv, tbl[i].d, tbl[i].m, tbl[i].ds, tbl[i].en, tbl[i].ordy);
            chk("tbl_in_ready",  {31'd0, dmx.in_ready},  {31'd0, tbl[i].e_rdy});
            chk("tbl_sel",       {30'd0, dmx.sel},       {30'd0, tbl[i].e_sel});
            chk("tbl_out_valid", {28'd0, dmx.out_valid}, {28'd0, tbl[i].e_ov});
            chk("tbl_out_data",  {24'd0, dmx.out_data},  {24'd0, tbl[i].e_od});
            chk("tbl_xfer_cnt",  {16'd0, dmx.xfer_cnt},  {16'd0, tbl[i].e_cnt});
        end

        // Fixed destination with a stalled sink
        step(0, 1, 8'h5A, 1, 2'd2, 4'h0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 8'h5B, 1, 2'd2, 4'h0, 4'h0);
            chk("stall_out_valid", {28'd0, dmx.out_valid}, 32'h4);
            chk("stall_out_data",  {24'd0, dmx.out_data}, 32'h5A);
            chk("stall_in_ready",  {31'd0, dmx.in_ready}, 32'h0);
        end
        step(0, 1, 8'h5B, 1, 2'd2, 4'h0, 4'b0100);
        chk("release_in_ready", {31'd0, dmx.in_ready}, 32'h1);
        step(0, 0, 8'h00, 1, 2'd2, 4'h0, 4'b0100);
        chk("passthru_data", {24'd0, dmx.out_data}, 32'h5B);
        chk("passthru_cnt",  {16'd0, dmx.xfer_cnt}, 32'd9);

        // No enabled lane: nothing accepted until lane 2 is enabled
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 8'hC0, 0, 2'd0, 4'h0, 4'hF);
            chk("noen_in_ready",  {31'd0, dmx.in_ready}, 32'h0);
            chk("noen_out_valid", {28'd0, dmx.out_valid}, 32'h0);
        end
        step(0, 1, 8'hC0, 0, 2'd0, 4'b0100, 4'h0);
        step(0, 0, 8'h00, 0, 2'd0, 4'b0100, 4'h0);
        chk("en2_sel", {30'd0, dmx.sel}, 32'd2);
        chk("en2_out_valid", {28'd0, dmx.out_valid}, 32'h4);

        // Reset discards a word held on lane 3
        step(0, 1, 8'hD3, 1, 2'd3, 4'h0, 4'b0100);
        step(0, 0, 8'h00, 1, 2'd3, 4'h0, 4'h0);
        chk("hold3_out_valid", {28'd0, dmx.out_valid}, 32'h8);
        step(1, 0, 8'h00, 1, 2'd3, 4'h0, 4'h0);
        step(0, 0, 8'h00, 1, 2'd3, 4'h0, 4'hF);
        chk("rst_out_valid", {28'd0, dmx.out_valid}, 32'h0);
        chk("rst_sel",       {30'd0, dmx.sel}, 32'd0);
        chk("rst_xfer_cnt",  {16'd0, dmx.xfer_cnt}, 32'd0);

        // Counter wrap from a preset of all-ones
        force dut.xfer_cnt_q = 16'hFFFF;
        #1;
        release dut.xfer_cnt_q;
        m_cnt = 16'hFFFF;
        step(0, 1, 8'hE0, 1, 2'd1, 4'h0, 4'hF);
        step(0, 0, 8'h00, 1, 2'd1, 4'h0, 4'hF);
        chk("preset_cnt", {16'd0, dmx.xfer_cnt}, 32'hFFFF);
        step(0, 0, 8'h00, 1, 2'd1, 4'h0, 4'hF);
        chk("wrap_cnt", {16'd0, dmx.xfer_cnt}, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 97) == 0,
                 ($urandom % 4) != 0,
                 8'($urandom),
                 ($urandom % 4) == 0,
                 2'($urandom),
                 4'($urandom),
                 ($urandom % 3) == 0 ? 4'hF : 4'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/demux_rr_dispatch.md
Name: demux_rr_dispatch

Overview:
Controller that sequences a 1x4 demultiplexer datapath. It accepts words from a single valid/ready source, buffers one word, and routes it to one of four output lanes. Lanes are chosen round-robin over enabled lanes, or taken from a fixed destination. It drives the lane select (S-style 2-bit code), per-lane valid strobes and a shared data bus, and counts completed transfers.

Parameters:
WIDTH, 8, data word width in bits
CNT_W, 16, width of the transfer counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  source word available
in_data  input  WIDTH  source word
in_ready  output  1  controller can accept a word this cycle
mode  input  1  0 = round-robin, 1 = fixed destination
dest  input  2  destination lane in fixed mode
lane_en  input  4  per-lane enable mask, used in round-robin mode only
sel  output  2  lane code of the held word (demux select)
out_valid  output  4  one-hot valid on lane sel while a word is held; 0 otherwise
out_data  output  WIDTH  held word, shared by all lanes
out_ready  input  4  per-lane sink ready
xfer_cnt  output  CNT_W  number of completed output transfers, wraps modulo 2^CNT_W

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high; rst is sampled on the rising edge of clk.
- Reset values: state=IDLE, sel=0, rr_ptr=0, out_data=0, out_valid=0000, xfer_cnt=0. in_ready follows its combinational equation.
- Reset mid-operation: a held word is discarded. No out_valid is asserted in the cycle after reset.
- State machine:
  - IDLE: buffer empty.
  - HOLD: buffer full.
- Target lane (tgt), evaluated combinationally from current inputs:
  - mode=1: tgt=dest.
  - mode=0: tgt = first lane i with lane_en[i]=1, searching rr_ptr, rr_ptr+1, ... modulo 4.
  - can_route = mode | (|lane_en).
- Output transfer: fire_out = (state==HOLD) & out_ready[sel].
- in_ready equation:
  - IDLE: in_ready = can_route.
  - HOLD: in_ready = can_route & out_ready[sel] (pass-through; one word per cycle sustained).
  - For round-robin pass-through, tgt uses rr_ptr_next = sel+1 (modulo 4), not the registered rr_ptr.
- Accept: fire_in = in_valid & in_ready. On fire_in:
  - out_data <= in_data, sel <= tgt, state <= HOLD.
  - mode, dest and lane_en are sampled only at accept. Later changes do not retarget a held word.
- Completion: on fire_out:
  - xfer_cnt <= xfer_cnt+1 (wraps from all-ones to 0).
  - rr_ptr <= sel+1 modulo 4 (3 wraps to 0).
  - If fire_in is also true in the same cycle, state stays HOLD with the new word. Otherwise state <= IDLE.
- out_valid = (state==HOLD) ? (4'b0001 << sel) : 4'b0000. Never more than one bit set.
- Ready on non-selected lanes is ignored.
- Latency: a word accepted in cycle n is presented on out_valid/out_data in cycle n+1. Back-to-back throughput is 1 word/cycle when the sink is ready.
- Held word is stable: out_data and sel do not change while out_valid=1 and out_ready[sel]=0.
- Round-robin mode with lane_en=0000: in_ready=0 and no word is accepted; a word already held still completes.
- Fixed mode ignores lane_en. A fixed-mode transfer also advances rr_ptr to dest+1.

Test Plan:
1. Reset, then mode=0, lane_en=1111, all out_ready=1, stream 0xA0,0xA1,0xA2,0xA3,0xA4 back-to-back -> sel sequence 0,1,2,3,0. One word per cycle; out_valid sequence 0001,0010,0100,1000,0001; xfer_cnt=5.
2. mode=0, lane_en=1010, rr_ptr=0, send 3 words -> sel 1,3,1. Lanes 0 and 2 never see out_valid.
3. mode=1, dest=2, out_ready=0000 for 3 cycles, then out_ready[2]=1, in_valid held with 0x5A then 0x5B -> out_valid=0100 with out_data=0x5A stable for 3 cycles. in_ready=0 during stall. Transfer completes, then 0x5B is accepted in the same cycle.
4. mode=0, lane_en=0000, in_valid=1 -> in_ready=0, out_valid=0000 indefinitely. Set lane_en=0100 -> word accepted and routed with sel=2.
5. Word held on lane 3 with out_ready=0, assert rst for 1 cycle -> next cycle out_valid=0000, sel=0, xfer_cnt=0, state IDLE; held word lost.
6. Preload xfer_cnt to 0xFFFF (CNT_W=16) through 65535 transfers, or by a forced preset in the bench, then 1 more transfer -> xfer_cnt=0x0000.
